// File: rtl/lock_checker_pkg.sv
// lock_pkg: shared definitions for the code-entry lock checker.
//   - default parameter values (word width, failure limit, timer lengths)
//   - FSM state encoding (IDLE/S0/S1/S2/OPEN/LOCK)
//   - STAGE output encoding
//   - max_int helper used to size the shared cycle timer
package lock_pkg;

   localparam int WIDTH_DEF          = 5;
   localparam int MAX_FAILS_DEF      = 3;
   localparam int LOCKOUT_CYCLES_DEF = 100;
   localparam int UNLOCK_CYCLES_DEF  = 50;

   // State encoding. The value of lock_checker.state_q is the debug view of the FSM.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_OPEN = 3'd4,
      ST_LOCK = 3'd5
   } state_t;

   // STAGE: number of digits already taken in the current attempt.
   localparam logic [1:0] STAGE_NONE = 2'd0;
   localparam logic [1:0] STAGE_ONE  = 2'd1;
   localparam logic [1:0] STAGE_TWO  = 2'd2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lock_checker_cycle_timer.sv
// cycle_timer: loadable down-counter that stops at zero.
// Ports:
//   CLK   in        rising-edge clock
//   RST   in        synchronous active-high reset (count clears to 0)
//   LOAD  in        load VALUE on this edge (has priority over counting)
//   VALUE in [TW]   value to load
//   ZERO  out       count is zero (registered count, decoded)
module cycle_timer #(
   parameter int TW = 7
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          LOAD,
   input  logic [TW-1:0] VALUE,
   output logic          ZERO
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (LOAD) begin
         cnt_d = VALUE;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/lock_checker.sv
// lock_checker: three-digit code-entry checker fed by the combination ALU.
// The verdict is only given after the third digit, so a wrong digit is never
// identified. Counts consecutive failures, locks out after MAX_FAILS, and
// relocks automatically after an open window.
//
// ENTER is a one-cycle strobe qualifying KEY: every cycle it is high while the
// FSM is in S0/S1/S2 (and COMBO_VALID is high) consumes one digit; there is no
// back-pressure, and strobes in IDLE/OPEN/LOCK are dropped.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   COMBO_VALID          COMBO0..2 hold a loaded combination
//   COMBO0/1/2 [WIDTH]   expected digits 1..3
//   KEY [WIDTH], ENTER   user digit and its sample strobe
//   RELOCK               close immediately while open
//   UNLOCKED             lock open (registered)
//   ERR                  one-cycle pulse on a failed attempt without lockout
//   LOCKOUT              lockout active (registered)
//   STAGE [2]            digits taken in current attempt
//   FAILS [2]            consecutive failed attempts
module lock_checker
   import lock_pkg::*;
#(
   parameter int WIDTH          = WIDTH_DEF,
   parameter int MAX_FAILS      = MAX_FAILS_DEF,
   parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
   parameter int UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             COMBO_VALID,
   input  logic [WIDTH-1:0] COMBO0,
   input  logic [WIDTH-1:0] COMBO1,
   input  logic [WIDTH-1:0] COMBO2,
   input  logic [WIDTH-1:0] KEY,
   input  logic             ENTER,
   input  logic             RELOCK,
   output logic             UNLOCKED,
   output logic             ERR,
   output logic             LOCKOUT,
   output logic [1:0]       STAGE,
   output logic [1:0]       FAILS
);

   // One timer serves both OPEN and LOCK; it only ever needs to hold max-1.
   localparam int TW = $clog2(max_int(LOCKOUT_CYCLES, UNLOCK_CYCLES));
   localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
   localparam logic [2:0]    MAX_FAILS_W = 3'(MAX_FAILS);

   state_t        state_q, state_d;
   logic          mism_q, mism_d;
   logic [1:0]    stage_q, stage_d;
   logic [1:0]    fails_q, fails_d;
   logic          unlocked_q, unlocked_d;
   logic          err_q, err_d;
   logic          lockout_q, lockout_d;

   logic          timer_load;
   logic [TW-1:0] timer_value;
   logic          timer_zero;
   logic          digit_miss;
   logic          attempt_bad;
   logic [2:0]    fails_inc;

   cycle_timer #(.TW(TW)) u_timer (
      .CLK   (CLK),
      .RST   (RST),
      .LOAD  (timer_load),
      .VALUE (timer_value),
      .ZERO  (timer_zero)
   );

   always_comb begin
      digit_miss = 1'b0;
      case (state_q)
         ST_S0:   digit_miss = (KEY != COMBO0);
         ST_S1:   digit_miss = (KEY != COMBO1);
         ST_S2:   digit_miss = (KEY != COMBO2);
         default: digit_miss = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mism_d      = mism_q;
      stage_d     = stage_q;
      fails_d     = fails_q;
      err_d       = 1'b0;
      timer_load  = 1'b0;
      timer_value = UNLOCK_LOAD;
      attempt_bad = mism_q | digit_miss;
      fails_inc   = {1'b0, fails_q} + 3'd1;

      if (state_q == ST_LOCK) begin
         // Lockout outranks a combination reload: it runs to completion.
         if (timer_zero) begin
            fails_d = 2'd0;
            state_d = COMBO_VALID ? ST_S0 : ST_IDLE;
         end
      end else if (!COMBO_VALID) begin
         // FAILS is deliberately kept so a reload cannot reset the count.
         state_d = ST_IDLE;
         stage_d = STAGE_NONE;
         mism_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_S0;
               stage_d = STAGE_NONE;
               mism_d  = 1'b0;
            end
            ST_OPEN: begin
               if (RELOCK || timer_zero) begin
                  state_d = ST_S0;
               end
            end
            ST_S0: begin
               if (ENTER) begin
                  mism_d  = attempt_bad;
                  stage_d = STAGE_ONE;
                  state_d = ST_S1;
               end
            end
            ST_S1: begin
               if (ENTER) begin
                  mism_d  = attempt_bad;
                  stage_d = STAGE_TWO;
                  state_d = ST_S2;
               end
            end
            ST_S2: begin
               if (ENTER) begin
                  stage_d = STAGE_NONE;
                  mism_d  = 1'b0;
                  if (!attempt_bad) begin
                     state_d     = ST_OPEN;
                     fails_d     = 2'd0;
                     timer_load  = 1'b1;
                     timer_value = UNLOCK_LOAD;
                  end else if (fails_inc < MAX_FAILS_W) begin
                     state_d = ST_S0;
                     fails_d = fails_inc[1:0];
                     err_d   = 1'b1;
                  end else begin
                     state_d     = ST_LOCK;
                     fails_d     = MAX_FAILS_W[1:0];
                     timer_load  = 1'b1;
                     timer_value = LOCK_LOAD;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               stage_d = STAGE_NONE;
               mism_d  = 1'b0;
            end
         endcase
      end

      unlocked_d = (state_d == ST_OPEN);
      lockout_d  = (state_d == ST_LOCK);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         mism_q     <= 1'b0;
         stage_q    <= STAGE_NONE;
         fails_q    <= 2'd0;
         unlocked_q <= 1'b0;
         err_q      <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mism_q     <= mism_d;
         stage_q    <= stage_d;
         fails_q    <= fails_d;
         unlocked_q <= unlocked_d;
         err_q      <= err_d;
         lockout_q  <= lockout_d;
      end
   end

   assign UNLOCKED = unlocked_q;
   assign ERR      = err_q;
   assign LOCKOUT  = lockout_q;
   assign STAGE    = stage_q;
   assign FAILS    = fails_q;

endmodule

// File: doc/lock_checker.md
# lock_checker

Sequential code-entry checker that sits directly downstream of the combination ALU (`COMBO_ALU`) in the encoded lock machine. It takes the three encoded 5-bit combination words the ALU produces and accepts three user key entries, one per `ENTER` pulse. Only after the third entry does it decide whether to open the lock; it never reveals which digit was wrong. It counts failed attempts, imposes a timed lockout after too many failures, and automatically relocks after a timed open window.

## Interface
- `WIDTH`, 5: width of each combination word and key entry.
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout; valid range is 1–3.
- `LOCKOUT_CYCLES`, 100: lockout duration in clock cycles; must be ≥ 2.
- `UNLOCK_CYCLES`, 50: open-window duration in clock cycles; must be ≥ 2.

Ports:
- `CLK` in 1: the single clock; all logic is on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `COMBO_VALID` in 1: high while `COMBO0..2` hold a stable, loaded combination.
- `COMBO0`, `COMBO1`, `COMBO2` in `WIDTH` each: expected digits 1, 2 and 3, taken from ALU `out0`, `out1`, `out2`.
- `KEY` in `WIDTH`: the digit currently entered by the user.
- `ENTER` in 1: one-cycle strobe that samples `KEY`.
- `RELOCK` in 1: forces an immediate relock while open.
- `UNLOCKED` out 1: lock is open.
- `ERR` out 1: one-cycle pulse on a failed attempt that does not cause lockout.
- `LOCKOUT` out 1: lockout is active.
- `STAGE` out 2: count of digits entered so far in the current attempt (0–2).
- `FAILS` out 2: count of consecutive failed attempts.

## Operation
- States are IDLE, S0, S1, S2, OPEN and LOCK.
- Reset loads IDLE. Every output resets to 0: `UNLOCKED`, `ERR`, `LOCKOUT`, `STAGE`, `FAILS`. The mismatch flag and the cycle timer also clear.
- IDLE → S0 when `COMBO_VALID` is 1.
- In any state, if `COMBO_VALID` is 0 the next state is IDLE, because the combination is being reloaded.
  - `STAGE` and the mismatch flag clear.
  - `FAILS` is kept, so reloading the combination cannot be used to escape the failure count.
  - `LOCKOUT` and its timer are also kept: LOCK ignores `COMBO_VALID` until its timer expires.
- S0 / S1 / S2 with `ENTER` = 1:
  - Compare `KEY` against `COMBO0` / `COMBO1` / `COMBO2` respectively and OR any mismatch into the mismatch flag.
  - S0 advances to S1 and S1 to S2; `STAGE` increments.
- S2 with `ENTER` = 1 evaluates the final result (flag OR current compare):
  - All three digits match: go to OPEN, clear `FAILS`.
  - Any mismatch, `FAILS`+1 < `MAX_FAILS`: increment `FAILS`, pulse `ERR`, go to S0.
  - Any mismatch, `FAILS`+1 = `MAX_FAILS`: set `FAILS` to `MAX_FAILS`, go to LOCK, load the timer with `LOCKOUT_CYCLES`-1.
  - In every case `STAGE` returns to 0 and the mismatch flag clears.
- OPEN:
  - `UNLOCKED` is 1 and the timer is loaded with `UNLOCK_CYCLES`-1 on entry.
  - Go to S0 when the timer reaches 0 or when `RELOCK` is 1.
  - `ENTER` is ignored.
- LOCK:
  - `LOCKOUT` is 1 and `ENTER` is ignored.
  - When the timer reaches 0, clear `FAILS` and go to S0, or to IDLE if `COMBO_VALID` is 0.
- `RELOCK` is ignored in every state except OPEN.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `ENTER` is sampled at rising edge k. `STAGE`, `UNLOCKED`, `ERR` and `LOCKOUT` reflect that entry from edge k onward, giving 1-cycle latency.
- `UNLOCKED` stays high for exactly `UNLOCK_CYCLES` cycles unless `RELOCK` ends it earlier.
- `LOCKOUT` stays high for exactly `LOCKOUT_CYCLES` cycles.
- `ERR` is high for exactly one cycle per failed attempt.
- Priority, highest first:
  1. `RST`
  2. LOCK timer
  3. `COMBO_VALID` low
  4. `RELOCK`, or OPEN timer expiry
  5. `ENTER`
- `ENTER` held high for several cycles counts as one entry per cycle; debouncing is done upstream.
- Timer expiry and `RELOCK` in the same cycle in OPEN: the result is S0, once.
- A new `ENTER` on the same edge the block leaves OPEN or LOCK is ignored. Entries are counted from the following edge.

## Structure
- Shared package `lock_pkg` holds:
  - the state encoding (IDLE/S0/S1/S2/OPEN/LOCK as localparams);
  - default widths;
  - the `STAGE` encoding.
- Sub-module `cycle_timer`: a loadable down-counter with `CLK`, `RST`, `LOAD`, `VALUE` and `ZERO`. One instance is shared by OPEN and LOCK, since they never overlap. Size it to `$clog2(max(LOCKOUT_CYCLES, UNLOCK_CYCLES))`.
- The top level contains the FSM, the mismatch flag and the fails counter.

## Test plan
- **Reset.** Hold `RST`=1 for 2 cycles with `COMBO_VALID`=1 → all outputs 0, state IDLE. After release the state is S0 on the next edge.
- **Correct code.** `COMBO` = 1E/03/0A, enter 1E, 03, 0A on consecutive edges → `STAGE` goes 1, 2, 0. `UNLOCKED` is high for exactly 50 cycles, then the state returns to S0.
- **Wrong middle digit.** Enter 1E, 04, 0A → no mismatch indication until the third `ENTER`. Then `ERR` pulses for 1 cycle, `FAILS`=1, `UNLOCKED` stays 0.
- **Lockout.** Three wrong attempts → `LOCKOUT` high for 100 cycles. `ENTER` strobes during lockout are ignored. Afterwards `FAILS`=0 and a correct code opens the lock.
- **Relock.** Assert `RELOCK` 10 cycles into OPEN → `UNLOCKED` falls on the next edge.
- **Reload mid-attempt.** Drop `COMBO_VALID` after 2 digits → state IDLE, `STAGE`=0, `FAILS` unchanged. After restore, a full correct entry opens the lock.
